// File: rtl/add8_share_arb.sv
// Round-robin sequencer time-sharing one external 8-bit approximate adder; accept to rsp_valid takes SETTLE+1 cycles.
// Backpressure: a held response (rsp_valid & !rsp_ready) blocks all new grants until it is consumed.
module add8_share_arb #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [7:0]        add_a,
    output logic [7:0]        add_b,
    input  logic [8:0]        add_o,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [8:0]        rsp_sum,
    output logic              busy,
    output logic [15:0]       op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt;
    logic           gnt_vld;
    logic [3:0]     settle_cnt;
    logic [7:0]     op_a;
    logic [7:0]     op_b;
    logic [7:0]     sel_a;
    logic [7:0]     sel_b;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest below ptr.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i < int'(ptr))) begin
                gnt_vld = 1'b1;
                gnt     = IDW'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i >= int'(ptr))) begin
                gnt_vld = 1'b1;
                gnt     = IDW'(i);
            end
        end
    end

    always_comb begin
        sel_a     = 8'h00;
        sel_b     = 8'h00;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                sel_a        = req_a[i*8 +: 8];
                sel_b        = req_b[i*8 +: 8];
                req_ready[i] = (state == IDLE) && gnt_vld;
            end
        end
    end

    assign add_a = op_a;
    assign add_b = op_b;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            settle_cnt <= 4'd0;
            op_a       <= 8'h00;
            op_b       <= 8'h00;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_sum    <= 9'h000;
            op_count   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        rsp_id     <= gnt;
                        ptr        <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
                        settle_cnt <= 4'(SETTLE - 1);
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (settle_cnt == 4'd0) begin
                        rsp_sum   <= add_o;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                RESP: begin
                    // The grant for the next operation waits for the following IDLE cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add8_share_arb.sv
// Bench for add8_share_arb: instance 0 uses SETTLE=1, instance 1 uses SETTLE=4; both share clock and reset.
module tb_add8_share_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bit          approx_mode = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic [3:0]  req_valid [2];
    logic [3:0]  req_ready [2];
    logic [31:0] req_a     [2];
    logic [31:0] req_b     [2];
    logic [7:0]  add_a     [2];
    logic [7:0]  add_b     [2];
    logic [8:0]  add_o     [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [1:0]  rsp_id    [2];
    logic [8:0]  rsp_sum   [2];
    logic        busy      [2];
    logic [15:0] op_count  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External adder: exact, or a lower-part-OR approximate adder (low 2 bits ORed, no carry out of them).
    function automatic logic [8:0] ext_adder(input logic [7:0] a, input logic [7:0] b, input bit approx);
        if (!approx) return {1'b0, a} + {1'b0, b};
        return {({1'b0, a[7:2]} + {1'b0, b[7:2]}), (a[1:0] | b[1:0])};
    endfunction

    for (genvar j = 0; j < 2; j++) begin : g_dut
        add8_share_arb #(.NREQ(4), .IDW(2), .SETTLE(j == 0 ? 1 : 4)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[j]),
            .req_ready (req_ready[j]),
            .req_a     (req_a[j]),
            .req_b     (req_b[j]),
            .add_a     (add_a[j]),
            .add_b     (add_b[j]),
            .add_o     (add_o[j]),
            .rsp_valid (rsp_valid[j]),
            .rsp_ready (rsp_ready[j]),
            .rsp_id    (rsp_id[j]),
            .rsp_sum   (rsp_sum[j]),
            .busy      (busy[j]),
            .op_count  (op_count[j])
        );
        assign add_o[j] = ext_adder(add_a[j], add_b[j], approx_mode);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Transaction-level model: one operation in flight, timed from its accept cycle.
    int          m_ptr  [2];
    bit          m_busy [2];
    int          m_tacc [2];
    int          m_id   [2];
    logic [7:0]  m_a    [2];
    logic [7:0]  m_b    [2];
    logic [15:0] m_cnt  [2];
    int          ms, mg;

    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            ms = (j == 0) ? 1 : 4;
            if (rst) begin
                m_ptr[j] = 0; m_busy[j] = 1'b0; m_a[j] = 8'h00; m_b[j] = 8'h00; m_cnt[j] = 16'h0;
                chk($sformatf("i%0d rst req_ready", j), req_ready[j], 0);
                chk($sformatf("i%0d rst add_a", j), add_a[j], 0);
                chk($sformatf("i%0d rst add_b", j), add_b[j], 0);
                chk($sformatf("i%0d rst rsp_valid", j), rsp_valid[j], 0);
                chk($sformatf("i%0d rst rsp_id", j), rsp_id[j], 0);
                chk($sformatf("i%0d rst rsp_sum", j), rsp_sum[j], 0);
                chk($sformatf("i%0d rst busy", j), busy[j], 0);
                chk($sformatf("i%0d rst op_count", j), op_count[j], 0);
            end else begin
                chk($sformatf("i%0d op_count", j), op_count[j], m_cnt[j]);
                chk($sformatf("i%0d add_a", j), add_a[j], m_a[j]);
                chk($sformatf("i%0d add_b", j), add_b[j], m_b[j]);
                chk($sformatf("i%0d busy", j), busy[j], m_busy[j]);
                if (!m_busy[j]) begin
                    mg = -1;
                    for (int k = 0; k < 4; k++)
                        if (mg < 0 && req_valid[j][(m_ptr[j] + k) % 4]) mg = (m_ptr[j] + k) % 4;
                    chk($sformatf("i%0d req_ready", j), req_ready[j], (mg < 0) ? 0 : (1 << mg));
                    chk($sformatf("i%0d rsp_valid idle", j), rsp_valid[j], 0);
                    if (mg >= 0) begin
                        m_busy[j] = 1'b1;
                        m_tacc[j] = cyc;
                        m_id[j]   = mg;
                        m_a[j]    = req_a[j][8*mg +: 8];
                        m_b[j]    = req_b[j][8*mg +: 8];
                        m_ptr[j]  = (mg + 1) % 4;
                    end
                end else begin
                    chk($sformatf("i%0d req_ready busy", j), req_ready[j], 0);
                    if (cyc - m_tacc[j] <= ms) begin
                        chk($sformatf("i%0d rsp_valid exec", j), rsp_valid[j], 0);
                    end else begin
                        chk($sformatf("i%0d rsp_valid", j), rsp_valid[j], 1);
                        chk($sformatf("i%0d rsp_id", j), rsp_id[j], m_id[j]);
                        chk($sformatf("i%0d rsp_sum", j), rsp_sum[j], ext_adder(m_a[j], m_b[j], approx_mode));
                        if (rsp_ready[j]) begin
                            m_busy[j] = 1'b0;
                            m_cnt[j]  = m_cnt[j] + 16'd1;
                        end
                    end
                end
            end
        end
    end

    task automatic set_lane(input int j, input int lane, input logic [7:0] a, input logic [7:0] b);
        req_a[j][8*lane +: 8] = a;
        req_b[j][8*lane +: 8] = b;
    endtask

    // Called right after a grant; drops the request, scrambles operands, returns cycles to rsp_valid.
    task automatic wait_rsp(input int j, output int n);
        tick();
        req_valid[j] = 4'h0;
        req_a[j] = 32'hA5A5A5A5;
        req_b[j] = 32'h5A5A5A5A;
        samp();
        n = 1;
        while (!rsp_valid[j] && n < 30) begin
            tick();
            samp();
            n++;
        end
    endtask

    task automatic wait_idle(input int j);
        int n;
        n = 0;
        samp();
        while (busy[j] && n < 50) begin
            tick();
            samp();
            n++;
        end
        chk("wait_idle bound", busy[j], 0);
    endtask

    task automatic pulse_rst();
        tick();
        rst = 1'b1;
        req_valid[0] = 4'h0;
        req_valid[1] = 4'h0;
        samp();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n, ng, nc, idx;
        int gl [8];
        int gc [8];
        for (int j = 0; j < 2; j++) begin
            req_valid[j] = 4'h0; req_a[j] = 32'h0; req_b[j] = 32'h0; rsp_ready[j] = 1'b1;
        end
        repeat (2) samp();
        chk("reset op_count", op_count[0], 16'h0000);
        chk("reset busy", busy[0], 0);
        tick();
        rst = 1'b0;

        // Single request, exact adder.
        tick();
        req_valid[0] = 4'b0001;
        set_lane(0, 0, 8'h10, 8'h20);
        samp();
        chk("t1 req_ready same cycle", req_ready[0], 4'b0001);
        wait_rsp(0, n);
        chk("t1 latency", n, 2);
        chk("t1 rsp_id", rsp_id[0], 0);
        chk("t1 rsp_sum", rsp_sum[0], 9'h030);
        tick();
        samp();
        chk("t1 op_count", op_count[0], 1);

        // All four requesters valid continuously.
        pulse_rst();
        req_valid[0] = 4'b1111;
        for (int i = 0; i < 4; i++) set_lane(0, i, 8'(i * 17 + 1), 8'(8'h40 + i));
        ng = 0;
        nc = 0;
        while (ng < 8 && nc < 60) begin
            samp();
            if (req_ready[0] != 4'h0) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (req_ready[0][i]) idx = i;
                gl[ng] = idx;
                gc[ng] = cyc;
                ng++;
            end
            nc++;
            if (ng < 8) tick();
        end
        chk("t2 grant count", ng, 8);
        for (int k = 0; k < ng; k++) begin
            chk($sformatf("t2 grant %0d", k), gl[k], k % 4);
            if (k > 0) chk($sformatf("t2 interval %0d", k), gc[k] - gc[k-1], 3);
        end
        tick();
        req_valid[0] = 4'h0;
        tick();
        tick();
        samp();
        chk("t2 op_count", op_count[0], 8);

        // Response backpressure.
        tick();
        rsp_ready[0] = 1'b0;
        req_valid[0] = 4'b0010;
        set_lane(0, 1, 8'hFF, 8'h01);
        samp();
        chk("t3 grant", req_ready[0], 4'b0010);
        wait_rsp(0, n);
        chk("t3 latency", n, 2);
        chk("t3 rsp_sum", rsp_sum[0], 9'h100);
        tick();
        req_valid[0] = 4'b1101;
        for (int i = 0; i < 10; i++) begin
            samp();
            chk("t3 stall rsp_valid", rsp_valid[0], 1);
            chk("t3 stall rsp_sum", rsp_sum[0], 9'h100);
            chk("t3 stall req_ready", req_ready[0], 4'h0);
            tick();
        end
        rsp_ready[0] = 1'b1;
        samp();
        tick();
        samp();
        chk("t3 resume grant", req_ready[0], 4'b0100);
        wait_rsp(0, n);

        // Approximate adder attached.
        wait_idle(0);
        tick();
        approx_mode = 1'b1;
        req_valid[0] = 4'b0001;
        set_lane(0, 0, 8'h03, 8'h05);
        samp();
        chk("t4 grant", req_ready[0], 4'b0001);
        tick();
        req_valid[0] = 4'h0;
        samp();
        chk("t4 exec add_a", add_a[0], 8'h03);
        chk("t4 exec add_b", add_b[0], 8'h05);
        tick();
        samp();
        chk("t4 rsp_valid", rsp_valid[0], 1);
        chk("t4 approx rsp_sum", rsp_sum[0], 9'h007);
        tick();
        samp();
        tick();
        approx_mode = 1'b0;

        // SETTLE=4 instance: wrap search from pointer 3.
        req_valid[1] = 4'b0100;
        set_lane(1, 2, 8'h01, 8'h02);
        samp();
        chk("t5 first grant", req_ready[1], 4'b0100);
        wait_rsp(1, n);
        chk("t5 first latency", n, 5);
        tick();
        samp();
        tick();
        req_valid[1] = 4'b0100;
        set_lane(1, 2, 8'h21, 8'h42);
        samp();
        chk("t5 wrap grant", req_ready[1], 4'b0100);
        wait_rsp(1, n);
        chk("t5 latency", n, 5);
        chk("t5 rsp_sum", rsp_sum[1], 9'h063);
        chk("t5 rsp_id", rsp_id[1], 2);
        tick();
        samp();
        tick();
        req_valid[1] = 4'b1001;
        samp();
        chk("t5 pointer at 3", req_ready[1], 4'b1000);
        wait_rsp(1, n);
        wait_idle(1);

        // Reset during EXEC.
        wait_idle(0);
        tick();
        req_valid[0] = 4'b0001;
        set_lane(0, 0, 8'h07, 8'h09);
        samp();
        chk("t6 grant", req_ready[0], 4'b0001);
        tick();
        req_valid[0] = 4'h0;
        rst = 1'b1;
        #1;
        chk("t6 async busy", busy[0], 0);
        chk("t6 async add_a", add_a[0], 8'h00);
        chk("t6 async op_count", op_count[0], 16'h0000);
        chk("t6 async rsp_valid", rsp_valid[0], 0);
        samp();
        tick();
        rst = 1'b0;
        req_valid[0] = 4'b0001;
        samp();
        chk("t6 regrant", req_ready[0], 4'b0001);
        wait_rsp(0, n);
        chk("t6 latency", n, 2);
        chk("t6 rsp_sum", rsp_sum[0], 9'h010);
        tick();
        samp();
        chk("t6 op_count", op_count[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
